intersection_sched: RTL

INTERSECTION_SCHED -- requirements
Module: intersection_sched

---
 rtl/intersection_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/intersection_sched.sv
// Traffic/pedestrian intersection scheduler: main road rests green, side road and walk served on request.
// Optional define PED_FLASH_EN makes the walk lamp blink during the last FLASH_T seconds.
module intersection_sched #(
  parameter int GREEN_MIN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int SIDE_T    = 8,
  parameter int PED_T     = 6,
  parameter int FLASH_T   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       secunda,
  input  logic       button,
  input  logic       req_side,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       redpieton,
  output logic       greenpieton,
  output logic [2:0] state,
  output logic       ped_pending,
  output logic       side_pending
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED     = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    PED_WALK    = 3'd5,
    CLEAR       = 3'd6
  } state_t;

  // Reject out-of-range timings at elaboration rather than misbehave silently.
  if (GREEN_MIN < 1 || GREEN_MIN > 255 || YELLOW_T < 1 || YELLOW_T > 255 ||
      ALLRED_T < 1 || ALLRED_T > 255 || SIDE_T < 1 || SIDE_T > 255 ||
      PED_T < 1 || PED_T > 255 || FLASH_T < 1 || FLASH_T > PED_T) begin : g_bad_cfg
    $error("intersection_sched: timing parameter out of range");
  end

  state_t     cur_state, next_state;
  logic [7:0] timer;
  logic       expired;
  logic       last_side;
  logic       serve_ped;
  logic       ped_enter;
  logic       side_enter;

  function automatic logic [7:0] duration(input state_t s);
    case (s)
      MAIN_YELLOW, SIDE_YELLOW: return 8'(YELLOW_T);
      ALL_RED, CLEAR:           return 8'(ALLRED_T);
      SIDE_GREEN:               return 8'(SIDE_T);
      PED_WALK:                 return 8'(PED_T);
      default:                  return 8'(GREEN_MIN);
    endcase
  endfunction

  assign expired    = (timer == 8'd0);
  // On a tie, serve whichever requester was not served last.
  assign serve_ped  = ped_pending && (!side_pending || last_side);
  assign ped_enter  = (next_state == PED_WALK) && (cur_state != PED_WALK);
  assign side_enter = (next_state == SIDE_GREEN) && (cur_state != SIDE_GREEN);
  assign state      = cur_state;

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      MAIN_GREEN:  if (expired && (ped_pending || side_pending)) next_state = MAIN_YELLOW;
      MAIN_YELLOW: if (expired) next_state = ALL_RED;
      ALL_RED: begin
        if (expired) begin
          if (serve_ped)         next_state = PED_WALK;
          else if (side_pending) next_state = SIDE_GREEN;
          else                   next_state = MAIN_GREEN;
        end
      end
      SIDE_GREEN:  if (expired) next_state = SIDE_YELLOW;
      SIDE_YELLOW: if (expired) next_state = CLEAR;
      PED_WALK:    if (expired) next_state = CLEAR;
      CLEAR:       if (expired) next_state = MAIN_GREEN;
      default:     next_state = MAIN_GREEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state    <= MAIN_GREEN;
      timer        <= 8'(GREEN_MIN);
      ped_pending  <= 1'b0;
      side_pending <= 1'b0;
      last_side    <= 1'b1;
    end else begin
      cur_state <= next_state;
      if (next_state != cur_state)
        timer <= duration(next_state);
      else if (secunda && !expired)
        timer <= timer - 8'd1;

      if (ped_enter)
        ped_pending <= 1'b0;
      else if (button && cur_state != PED_WALK)
        ped_pending <= 1'b1;

      if (side_enter)
        side_pending <= 1'b0;
      else if (req_side && cur_state != SIDE_GREEN)
        side_pending <= 1'b1;

      if (ped_enter)
        last_side <= 1'b0;
      else if (side_enter)
        last_side <= 1'b1;
    end
  end

`ifdef PED_FLASH_EN
  logic flash;

  always_ff @(posedge clk) begin
    if (!rst)
      flash <= 1'b1;
    else if (ped_enter)
      flash <= 1'b1;
    else if (cur_state == PED_WALK && secunda && timer <= 8'(FLASH_T))
      flash <= ~flash;
  end

  assign greenpieton = (cur_state == PED_WALK) && flash;
`else
  assign greenpieton = (cur_state == PED_WALK);
`endif

  // Walk phase keeps the red hand dark even while the green man blinks off.
  assign redpieton = (cur_state != PED_WALK);

  always_comb begin
    main_red    = 1'b1;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b1;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    case (cur_state)
      MAIN_GREEN:  begin main_green  = 1'b1; main_red = 1'b0; end
      MAIN_YELLOW: begin main_yellow = 1'b1; main_red = 1'b0; end
      SIDE_GREEN:  begin side_green  = 1'b1; side_red = 1'b0; end
      SIDE_YELLOW: begin side_yellow = 1'b1; side_red = 1'b0; end
      default: ;
    endcase
  end

endmodule
